// File: rtl/scpad_pkg.sv
// ============================================================================
//  Module      : scpad_pkg
//  Description : Shared scratchpad types and sizes. Provides the DRAM response
//                beat type, the per-id read tracking entry and a helper that
//                builds the "all beats received" mask.
//  Config      : DRAM_RSP_SUBID_CHECK_EN adds an 8-bit received-beat mask to
//                the tracking entry.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package scpad_pkg;

  localparam int DRAM_ID_WIDTH    = 4;
  localparam int DRAM_RSP_DEPTH   = 8;
  localparam int SCPAD_DATA_WIDTH = 128;

  typedef logic [SCPAD_DATA_WIDTH-1:0] scpad_data_t;
  typedef logic [DRAM_ID_WIDTH-1:0]    dram_id_t;

  // One DRAM read-response beat as it sits in the response FIFO.
  typedef struct packed {
    dram_id_t    id;
    logic [2:0]  sub_id;
    scpad_data_t data;
  } dram_rsp_t;

  // Per-id tracking entry. expected holds beats-minus-one of the request.
  typedef struct packed {
    logic       busy;
    logic [2:0] expected;
    logic [2:0] count;
`ifdef DRAM_RSP_SUBID_CHECK_EN
    logic [7:0] mask;
`endif
  } rsp_track_t;

  // Ones in bits 0..last: the mask a request is complete at.
  function automatic logic [7:0] beats_mask(input logic [2:0] last);
    return 8'hFF >> (3'd7 - last);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dram_rsp_fifo.sv
// ============================================================================
//  Module      : dram_rsp_fifo
//  Description : Generic synchronous FIFO of response beats. Pointers carry
//                one extra MSB so full and empty are told apart without a
//                separate counter. Push is ignored when full, pop when empty.
//  Ports       : CLK, nRST (async active-low)
//                push/push_data  - write side
//                pop/head        - read side, head is the oldest entry
//                full/empty      - occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dram_rsp_fifo
  import scpad_pkg::*;
#(
  parameter int  DEPTH = DRAM_RSP_DEPTH,
  parameter type T     = dram_rsp_t
) (
  input  logic CLK,
  input  logic nRST,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  T            mem_q [DEPTH];
  T            mem_d [DEPTH];

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    // Same slot, opposite lap bit: the writer is a whole lap ahead.
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dram_rsp_queue.sv
// ============================================================================
//  Module      : dram_rsp_queue
//  Description : Buffers DRAM read-response beats, drains them to the
//                scratchpad SRAM write port under backend stall, and tracks
//                beats per id to pulse a completion once a whole read request
//                has been written.
//  Ports       : CLK, nRST              clock, async active-low reset
//                alloc_*                read issued by the request queue
//                dram_rsp_*             incoming beats (valid/ready)
//                sram_wr_*              head beat toward SRAM
//                be_stall               head pops on sram_wr_valid & !be_stall
//                be_dram_rd_req_complete/complete_id  one-cycle completion
//                rsp_queue_full, rsp_err              status / error pulse
//  Config      : DRAM_RSP_SUBID_CHECK_EN - drop duplicate or out-of-range
//                sub_ids and require every sub_id before completing.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dram_rsp_queue
  import scpad_pkg::*;
#(
  parameter int DEPTH  = DRAM_RSP_DEPTH,
  parameter int ID_W   = DRAM_ID_WIDTH,
  parameter int DATA_W = SCPAD_DATA_WIDTH
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              alloc_valid,
  input  logic [ID_W-1:0]   alloc_id,
  input  logic [2:0]        alloc_num_request,
  input  logic              dram_rsp_valid,
  input  logic [ID_W-1:0]   dram_rsp_id,
  input  logic [2:0]        dram_rsp_sub_id,
  input  logic [DATA_W-1:0] dram_rsp_data,
  output logic              dram_rsp_ready,
  output logic              sram_wr_valid,
  output logic [ID_W-1:0]   sram_wr_id,
  output logic [2:0]        sram_wr_sub_id,
  output logic [DATA_W-1:0] sram_wr_data,
  input  logic              be_stall,
  output logic              be_dram_rd_req_complete,
  output logic [ID_W-1:0]   complete_id,
  output logic              rsp_queue_full,
  output logic              rsp_err
);

  localparam int ENTRIES = 2 ** ID_W;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [2:0]        sub_id;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t           push_beat;
  beat_t           head_beat;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            discard;
  logic            final_beat;
  rsp_track_t      head_entry;
  rsp_track_t      table_q [ENTRIES];
  rsp_track_t      table_d [ENTRIES];
  logic            err_q, err_d;
  logic            cmpl_q, cmpl_d;
  logic [ID_W-1:0] cmpl_id_q, cmpl_id_d;

  always_comb push_beat = '{id: dram_rsp_id, sub_id: dram_rsp_sub_id, data: dram_rsp_data};

  dram_rsp_fifo #(
    .DEPTH (DEPTH),
    .T     (beat_t)
  ) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (dram_rsp_valid),
    .push_data (push_beat),
    .pop       (pop),
    .head      (head_beat),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Classify the head beat against its tracking entry.
  always_comb begin
    head_entry = table_q[head_beat.id];
    discard    = 1'b0;
`ifdef DRAM_RSP_SUBID_CHECK_EN
    // A repeated or out-of-range sub_id is dropped; it leaves the FIFO
    // without waiting on be_stall because nothing is written for it.
    discard    = !fifo_empty && head_entry.busy &&
                 (head_entry.mask[head_beat.sub_id] ||
                  (head_beat.sub_id > head_entry.expected));
    final_beat = ((head_entry.mask | (8'h01 << head_beat.sub_id)) ==
                  beats_mask(head_entry.expected));
`else
    final_beat = (head_entry.count == head_entry.expected);
`endif
    pop = !fifo_empty && (!be_stall || discard);
  end

  // Table update: the pop is applied first so that an alloc landing on an id
  // whose final beat pops this same cycle sees a free entry and wins it.
  always_comb begin
    table_d   = table_q;
    err_d     = 1'b0;
    cmpl_d    = 1'b0;
    cmpl_id_d = '0;

    if (pop) begin
      if (!head_entry.busy || discard) begin
        err_d = 1'b1;
      end else if (final_beat) begin
        table_d[head_beat.id] = '0;
        cmpl_d                = 1'b1;
        cmpl_id_d             = head_beat.id;
      end else begin
        table_d[head_beat.id].count = head_entry.count + 3'd1;
`ifdef DRAM_RSP_SUBID_CHECK_EN
        table_d[head_beat.id].mask[head_beat.sub_id] = 1'b1;
`endif
      end
    end

    if (alloc_valid) begin
      if (table_d[alloc_id].busy) err_d = 1'b1;
      table_d[alloc_id]          = '0;
      table_d[alloc_id].busy     = 1'b1;
      table_d[alloc_id].expected = alloc_num_request;
    end
  end

  always_comb begin
    dram_rsp_ready          = !fifo_full;
    rsp_queue_full          = fifo_full;
    sram_wr_valid           = !fifo_empty && !discard;
    sram_wr_id              = fifo_empty ? '0 : head_beat.id;
    sram_wr_sub_id          = fifo_empty ? '0 : head_beat.sub_id;
    sram_wr_data            = fifo_empty ? '0 : head_beat.data;
    be_dram_rd_req_complete = cmpl_q;
    complete_id             = cmpl_id_q;
    rsp_err                 = err_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= '0;
      err_q     <= 1'b0;
      cmpl_q    <= 1'b0;
      cmpl_id_q <= '0;
    end else begin
      table_q   <= table_d;
      err_q     <= err_d;
      cmpl_q    <= cmpl_d;
      cmpl_id_q <= cmpl_id_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dram_rsp_queue.sv
// ============================================================================
//  Module      : tb_dram_rsp_queue
//  Description : Self-checking bench for dram_rsp_queue: a table of directed
//                vectors, hand sequences for stall/full/reset corners, and a
//                randomized phase compared against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dram_rsp_queue;

  localparam int DEPTH = 8;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         alloc_valid;
  logic [3:0]   alloc_id;
  logic [2:0]   alloc_num_request;
  logic         dram_rsp_valid;
  logic [3:0]   dram_rsp_id;
  logic [2:0]   dram_rsp_sub_id;
  logic [127:0] dram_rsp_data;
  logic         dram_rsp_ready;
  logic         sram_wr_valid;
  logic [3:0]   sram_wr_id;
  logic [2:0]   sram_wr_sub_id;
  logic [127:0] sram_wr_data;
  logic         be_stall;
  logic         be_dram_rd_req_complete;
  logic [3:0]   complete_id;
  logic         rsp_queue_full;
  logic         rsp_err;

  dram_rsp_queue dut (
    .CLK                     (CLK),
    .nRST                    (nRST),
    .alloc_valid             (alloc_valid),
    .alloc_id                (alloc_id),
    .alloc_num_request       (alloc_num_request),
    .dram_rsp_valid          (dram_rsp_valid),
    .dram_rsp_id             (dram_rsp_id),
    .dram_rsp_sub_id         (dram_rsp_sub_id),
    .dram_rsp_data           (dram_rsp_data),
    .dram_rsp_ready          (dram_rsp_ready),
    .sram_wr_valid           (sram_wr_valid),
    .sram_wr_id              (sram_wr_id),
    .sram_wr_sub_id          (sram_wr_sub_id),
    .sram_wr_data            (sram_wr_data),
    .be_stall                (be_stall),
    .be_dram_rd_req_complete (be_dram_rd_req_complete),
    .complete_id             (complete_id),
    .rsp_queue_full          (rsp_queue_full),
    .rsp_err                 (rsp_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]   id;
    logic [2:0]   sub;
    logic [127:0] data;
  } mbeat_t;

  mbeat_t     mq[$];
  logic       m_busy [16];
  int         m_exp  [16];
  int         m_got  [16];
  logic [7:0] m_mask [16];
  logic       m_err, m_cmpl;
  logic [3:0] m_cid;

  logic [6:0] wlog[$];   // {id,sub} of every beat actually written
  logic [3:0] clog[$];   // completion ids in order
  int         errcnt;

  function automatic logic [127:0] dat(input logic [3:0] id, input logic [2:0] sub);
    return {16{8'hA5}} ^ {121'd0, id, sub};
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 16; i++) begin
      m_busy[i] = 1'b0; m_exp[i] = 0; m_got[i] = 0; m_mask[i] = 8'h00;
    end
    m_err = 1'b0; m_cmpl = 1'b0; m_cid = 4'd0;
  endtask

  function automatic logic m_discard_head();
    logic d;
    d = 1'b0;
`ifdef DRAM_RSP_SUBID_CHECK_EN
    if (mq.size() > 0)
      d = m_busy[mq[0].id] &&
          (m_mask[mq[0].id][mq[0].sub] || (int'(mq[0].sub) > m_exp[mq[0].id]));
`endif
    return d;
  endfunction

  task automatic model_step(input logic av, input logic [3:0] aid, input logic [2:0] anum,
                            input logic rv, input mbeat_t rb, input logic st);
    logic   room, disc, do_pop;
    mbeat_t h;
    m_err  = 1'b0;
    m_cmpl = 1'b0;
    m_cid  = 4'd0;
    room   = (mq.size() < DEPTH);
    disc   = m_discard_head();
    do_pop = (mq.size() > 0) && (!st || disc);
    if (do_pop) begin
      h = mq.pop_front();
      if (!m_busy[h.id] || disc) begin
        m_err = 1'b1;
      end else begin
        m_got[h.id]++;
        m_mask[h.id][h.sub] = 1'b1;
        if (m_got[h.id] == m_exp[h.id] + 1) begin
          m_busy[h.id] = 1'b0;
          m_cmpl = 1'b1;
          m_cid  = h.id;
        end
      end
    end
    if (av) begin
      if (m_busy[aid]) m_err = 1'b1;
      m_busy[aid] = 1'b1; m_exp[aid] = int'(anum); m_got[aid] = 0; m_mask[aid] = 8'h00;
    end
    if (rv && room) mq.push_back(rb);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_ctl();
    return {dram_rsp_ready, rsp_queue_full, sram_wr_valid, sram_wr_id, sram_wr_sub_id,
            be_dram_rd_req_complete, complete_id, rsp_err};
  endfunction

  task automatic check_model(input string tag);
    mbeat_t h;
    logic   wv;
    h  = (mq.size() > 0) ? mq[0] : '0;
    wv = (mq.size() > 0) && !m_discard_head();
    chk({tag, " ctl"}, {112'd0, dut_ctl()},
        {112'd0, (mq.size() < DEPTH), (mq.size() == DEPTH), wv, h.id, h.sub, m_cmpl, m_cid, m_err});
    chk({tag, " data"}, sram_wr_data, h.data);
  endtask

  // One clock: drive inputs, record writes, step model, clock, check.
  task automatic tick(input logic av, input logic [3:0] aid, input logic [2:0] anum,
                      input logic rv, input logic [3:0] rid, input logic [2:0] rsub,
                      input logic [127:0] rdata, input logic st, input string tag);
    mbeat_t rb;
    alloc_valid = av; alloc_id = aid; alloc_num_request = anum;
    dram_rsp_valid = rv; dram_rsp_id = rid; dram_rsp_sub_id = rsub; dram_rsp_data = rdata;
    be_stall = st;
    if (sram_wr_valid && !st) wlog.push_back({sram_wr_id, sram_wr_sub_id});
    rb = '{id: rid, sub: rsub, data: rdata};
    model_step(av, aid, anum, rv, rb, st);
    @(posedge CLK);
    #1;
    if (be_dram_rd_req_complete) clog.push_back(complete_id);
    if (rsp_err) errcnt++;
    check_model(tag);
  endtask

  task automatic idle(input logic st, input string tag);
    tick(1'b0, 4'd0, 3'd0, 1'b0, 4'd0, 3'd0, 128'd0, st, tag);
  endtask

  task automatic beat(input logic [3:0] id, input logic [2:0] sub, input logic st, input string tag);
    tick(1'b0, 4'd0, 3'd0, 1'b1, id, sub, dat(id, sub), st, tag);
  endtask

  task automatic do_reset();
    alloc_valid = 1'b0; alloc_id = 4'd0; alloc_num_request = 3'd0;
    dram_rsp_valid = 1'b0; dram_rsp_id = 4'd0; dram_rsp_sub_id = 3'd0; dram_rsp_data = 128'd0;
    be_stall = 1'b0;
    nRST = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic av; logic [3:0] aid; logic [2:0] an;
    logic rv; logic [3:0] rid; logic [2:0] rs; logic st;
    logic ewv; logic [3:0] eid; logic [2:0] es; logic ec; logic [3:0] ecid; logic ee;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic av, input logic [3:0] aid, input logic [2:0] an,
                      input logic rv, input logic [3:0] rid, input logic [2:0] rs, input logic st,
                      input logic ewv, input logic [3:0] eid, input logic [2:0] es,
                      input logic ec, input logic [3:0] ecid, input logic ee);
    vec_t v;
    v = '{av, aid, an, rv, rid, rs, st, ewv, eid, es, ec, ecid, ee};
    vecs.push_back(v);
  endtask

  localparam logic [15:0] RESET_CTL = 16'h8000;  // ready=1, everything else 0

  initial begin
    do_reset();
    chk("reset ctl", {112'd0, dut_ctl()}, {112'd0, RESET_CTL});
    chk("reset data", sram_wr_data, 128'd0);

    // Single beat, interleaved ids, unallocated id, double alloc.
    addv(1'b1,4'd3,3'd0, 1'b0,4'd0,3'd0,1'b0, 1'b0,4'd0,3'd0, 1'b0,4'd0,1'b0);
    addv(1'b0,4'd0,3'd0, 1'b1,4'd3,3'd0,1'b0, 1'b1,4'd3,3'd0, 1'b0,4'd0,1'b0);
    addv(1'b0,4'd0,3'd0, 1'b0,4'd0,3'd0,1'b0, 1'b0,4'd0,3'd0, 1'b1,4'd3,1'b0);
    addv(1'b0,4'd0,3'd0, 1'b0,4'd0,3'd0,1'b0, 1'b0,4'd0,3'd0, 1'b0,4'd0,1'b0);
    addv(1'b1,4'd1,3'd1, 1'b1,4'd1,3'd0,1'b0, 1'b1,4'd1,3'd0, 1'b0,4'd0,1'b0);
    addv(1'b1,4'd2,3'd1, 1'b1,4'd2,3'd0,1'b0, 1'b1,4'd2,3'd0, 1'b0,4'd0,1'b0);
    addv(1'b0,4'd0,3'd0, 1'b1,4'd2,3'd1,1'b0, 1'b1,4'd2,3'd1, 1'b0,4'd0,1'b0);
    addv(1'b0,4'd0,3'd0, 1'b1,4'd1,3'd1,1'b0, 1'b1,4'd1,3'd1, 1'b1,4'd2,1'b0);
    addv(1'b0,4'd0,3'd0, 1'b0,4'd0,3'd0,1'b0, 1'b0,4'd0,3'd0, 1'b1,4'd1,1'b0);
    addv(1'b0,4'd0,3'd0, 1'b1,4'd7,3'd0,1'b0, 1'b1,4'd7,3'd0, 1'b0,4'd0,1'b0);
    addv(1'b0,4'd0,3'd0, 1'b0,4'd0,3'd0,1'b0, 1'b0,4'd0,3'd0, 1'b0,4'd0,1'b1);
    addv(1'b1,4'd1,3'd0, 1'b0,4'd0,3'd0,1'b0, 1'b0,4'd0,3'd0, 1'b0,4'd0,1'b0);
    addv(1'b1,4'd1,3'd0, 1'b0,4'd0,3'd0,1'b0, 1'b0,4'd0,3'd0, 1'b0,4'd0,1'b1);
    addv(1'b0,4'd0,3'd0, 1'b1,4'd1,3'd0,1'b0, 1'b1,4'd1,3'd0, 1'b0,4'd0,1'b0);
    addv(1'b0,4'd0,3'd0, 1'b0,4'd0,3'd0,1'b0, 1'b0,4'd0,3'd0, 1'b1,4'd1,1'b0);
    addv(1'b0,4'd0,3'd0, 1'b0,4'd0,3'd0,1'b0, 1'b0,4'd0,3'd0, 1'b0,4'd0,1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].av, vecs[i].aid, vecs[i].an, vecs[i].rv, vecs[i].rid, vecs[i].rs,
           dat(vecs[i].rid, vecs[i].rs), vecs[i].st, $sformatf("vec%0d model", i));
      chk($sformatf("vec%0d ctl", i), {112'd0, dut_ctl()},
          {112'd0, 1'b1, 1'b0, vecs[i].ewv, vecs[i].eid, vecs[i].es,
           vecs[i].ec, vecs[i].ecid, vecs[i].ee});
      chk($sformatf("vec%0d data", i), sram_wr_data,
          vecs[i].ewv ? dat(vecs[i].eid, vecs[i].es) : 128'd0);
    end

    // Burst of 4 with a 3-cycle stall in the middle.
    wlog.delete(); clog.delete();
    tick(1'b1, 4'd5, 3'd3, 1'b1, 4'd5, 3'd0, dat(4'd5, 3'd0), 1'b0, "burst0");
    beat(4'd5, 3'd1, 1'b0, "burst1");
    beat(4'd5, 3'd2, 1'b1, "burst2");
    beat(4'd5, 3'd3, 1'b1, "burst3");
    idle(1'b1, "burst4");
    repeat (5) idle(1'b0, "burst_drain");
    chk("burst writes", 128'(wlog.size()), 128'd4);
    for (int i = 0; i < wlog.size() && i < 4; i++)
      chk($sformatf("burst order%0d", i), {121'd0, wlog[i]}, {121'd0, 4'd5, 3'(i)});
    chk("burst completions", 128'(clog.size()), 128'd1);
    if (clog.size() > 0) chk("burst cmpl id", {124'd0, clog[0]}, 128'd5);

    // Fill the FIFO under stall, then release.
    for (int i = 0; i < DEPTH; i++) beat(4'd9, 3'(i), 1'b1, "fill");
    chk("full flag", {127'd0, rsp_queue_full}, 128'd1);
    chk("full ready", {127'd0, dram_rsp_ready}, 128'd0);
    beat(4'd9, 3'd0, 1'b1, "ninth");
    chk("ninth refused", {127'd0, dram_rsp_ready}, 128'd0);
    beat(4'd9, 3'd1, 1'b0, "first pop");
    chk("ready after pop", {127'd0, dram_rsp_ready}, 128'd1);
    chk("not full after pop", {127'd0, rsp_queue_full}, 128'd0);
    repeat (10) idle(1'b0, "full_drain");

`ifdef DRAM_RSP_SUBID_CHECK_EN
    // Duplicate sub_id is dropped and flagged.
    wlog.delete(); clog.delete(); errcnt = 0;
    tick(1'b1, 4'd4, 3'd1, 1'b1, 4'd4, 3'd0, dat(4'd4, 3'd0), 1'b0, "dup0");
    beat(4'd4, 3'd0, 1'b0, "dup1");
    beat(4'd4, 3'd1, 1'b0, "dup2");
    repeat (4) idle(1'b0, "dup_drain");
    chk("dup writes", 128'(wlog.size()), 128'd2);
    chk("dup errs", 128'(errcnt), 128'd1);
    chk("dup completions", 128'(clog.size()), 128'd1);
`endif

    // Reset in the middle of a burst.
    tick(1'b1, 4'd5, 3'd3, 1'b1, 4'd5, 3'd0, dat(4'd5, 3'd0), 1'b1, "mid0");
    beat(4'd5, 3'd1, 1'b1, "mid1");
    idle(1'b1, "mid2");
    chk("pre-reset valid", {127'd0, sram_wr_valid}, 128'd1);
    #3;
    nRST = 1'b0;
    model_reset();
    #1;
    chk("async reset ctl", {112'd0, dut_ctl()}, {112'd0, RESET_CTL});
    chk("async reset data", sram_wr_data, 128'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    clog.delete(); errcnt = 0;
    idle(1'b0, "post_rst0");
    tick(1'b1, 4'd5, 3'd0, 1'b1, 4'd5, 3'd0, dat(4'd5, 3'd0), 1'b0, "post_rst1");
    repeat (3) idle(1'b0, "post_rst2");
    chk("post-reset completions", 128'(clog.size()), 128'd1);
    if (clog.size() > 0) chk("post-reset cmpl id", {124'd0, clog[0]}, 128'd5);
    chk("post-reset errs", 128'(errcnt), 128'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] rid;
      logic [2:0] rs;
      rid = 4'($urandom_range(0, 7));
      rs  = 3'($urandom_range(0, 3));
      tick(($urandom % 5) == 0, 4'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
           ($urandom % 3) != 0, rid, rs, {$urandom, $urandom, $urandom, $urandom},
           ($urandom % 4) == 0, "random");
    end
    repeat (12) idle(1'b0, "final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
